// File: rtl/lsu.sv
// rtl/lsu.sv - RV32I load/store unit; LSU_MISALIGN_SPLIT_EN splits misaligned accesses into two word accesses
module lsu #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_fault,
    output logic [ADDR_W-1:0] mem_adr,
    output logic [3:0]        mem_we,
    output logic [31:0]       mem_wdata,
    output logic              mem_str,
    output logic              mem_ld,
    input  logic [31:0]       mem_rdata
);

`ifdef LSU_MISALIGN_SPLIT_EN
    localparam logic SPLIT_EN = 1'b1;
`else
    localparam logic SPLIT_EN = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, ISSUE0, ISSUE1, WAIT, RESP} state_t;

    state_t state_q, state_d;

    logic              accept;
    logic [3:0]        mask;
    logic              illegal;
    logic [7:0]        lanes;
    logic [63:0]       data64;
    logic              misaligned;
    logic [ADDR_W-1:0] word_addr;

    logic              we_q;
    logic [2:0]        f3_q;
    logic [1:0]        off_q;
    logic              split_q;
    logic [3:0]        hi_we_q;
    logic [31:0]       hi_wdata_q;
    logic [31:0]       lo_q;
    logic [63:0]       word64;
    logic [31:0]       rdata_fmt;

    logic              unused_addr_bits;
    assign unused_addr_bits = ^req_addr[31:ADDR_W+2];

    assign req_ready = (state_q == IDLE);
    assign accept    = req_valid && req_ready;
    assign word_addr = req_addr[ADDR_W+1:2];

    function automatic logic [31:0] load_fmt(input logic [31:0] w, input logic [2:0] f3);
        case (f3)
            3'b000:  load_fmt = {{24{w[7]}}, w[7:0]};
            3'b001:  load_fmt = {{16{w[15]}}, w[15:0]};
            3'b100:  load_fmt = {24'd0, w[7:0]};
            3'b101:  load_fmt = {16'd0, w[15:0]};
            default: load_fmt = w;
        endcase
    endfunction

    always_comb begin
        case (req_funct3[1:0])
            2'b01:   mask = 4'b0011;
            2'b10:   mask = 4'b1111;
            default: mask = 4'b0001;
        endcase
        illegal    = (req_funct3[1:0] == 2'b11) || (req_funct3[2] && (req_we || req_funct3[1]));
        lanes      = {4'b0000, mask} << req_addr[1:0];
        data64     = {32'd0, req_wdata} << {req_addr[1:0], 3'b000};
        misaligned = |lanes[7:4];
    end

    // Upper word of a split load is the live memory word; the lower one was latched in ISSUE1.
    always_comb begin
        word64    = split_q ? {mem_rdata, lo_q} : {32'd0, mem_rdata};
        rdata_fmt = load_fmt(32'(word64 >> {off_q, 3'b000}), f3_q);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (illegal || (misaligned && !SPLIT_EN)) state_d = RESP;
                    else                                       state_d = ISSUE0;
                end
            end
            ISSUE0:  state_d = split_q ? ISSUE1 : (we_q ? RESP : WAIT);
            ISSUE1:  state_d = we_q ? RESP : WAIT;
            WAIT:    state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_fault <= 1'b0;
            mem_adr    <= '0;
            mem_we     <= 4'd0;
            mem_wdata  <= 32'd0;
            mem_str    <= 1'b0;
            mem_ld     <= 1'b0;
            we_q       <= 1'b0;
            f3_q       <= 3'd0;
            off_q      <= 2'd0;
            split_q    <= 1'b0;
            hi_we_q    <= 4'd0;
            hi_wdata_q <= 32'd0;
            lo_q       <= 32'd0;
        end else begin
            resp_valid <= (state_d == RESP);
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        we_q       <= req_we;
                        f3_q       <= req_funct3;
                        off_q      <= req_addr[1:0];
                        split_q    <= SPLIT_EN && misaligned;
                        hi_we_q    <= lanes[7:4];
                        hi_wdata_q <= data64[63:32];
                        resp_rdata <= 32'd0;
                        resp_fault <= (state_d == RESP);
                        if (state_d == ISSUE0) begin
                            mem_adr   <= word_addr;
                            mem_we    <= lanes[3:0];
                            mem_wdata <= data64[31:0];
                            mem_str   <= req_we;
                            mem_ld    <= !req_we;
                        end
                    end
                end
                ISSUE0: begin
                    if (state_d == ISSUE1) begin
                        mem_adr   <= mem_adr + 1'b1;
                        mem_we    <= hi_we_q;
                        mem_wdata <= hi_wdata_q;
                    end else begin
                        mem_we  <= 4'd0;
                        mem_str <= 1'b0;
                        mem_ld  <= 1'b0;
                    end
                end
                ISSUE1: begin
                    mem_we  <= 4'd0;
                    mem_str <= 1'b0;
                    mem_ld  <= 1'b0;
                    lo_q    <= mem_rdata;
                end
                WAIT:    resp_rdata <= rdata_fmt;
                default: ;
            endcase
        end
    end

endmodule
